// File: rtl/rgb_gray_pattern_gen.sv
// Grayscale raster test-pattern source for LVDS link bring-up.
// Emits raster timing plus R=G=B pixels with optional one-pixel corruption.
module rgb_gray_pattern_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_en,
  input  logic [1:0]  I_mode,
  input  logic        I_err_inject,
  output logic [23:0] O_RGB_data,
  output logic        O_de,
  output logic        O_hsync,
  output logic        O_vsync,
  output logic        O_frame_start,
  output logic        O_err_injected
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic [31:0] HA     = 32'(H_ACTIVE);
  localparam logic [31:0] VA     = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          vld_q, vld_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          req_q;
  logic          pend_q, pend_d;

  logic [31:0] h32, v32;
  logic        act, hs_raw, vs_raw, consume;
  logic [7:0]  g;
  logic [23:0] rgb_d;

  assign h32 = 32'(h_q);
  assign v32 = 32'(v_q);

  // Frame FSM and raster counters; vld marks counters as a live position.
  // Every completed frame bumps frame_cnt, so a restart continues the count.
  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    h_d     = h_q;
    v_d     = v_q;
    fcnt_d  = fcnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        vld_d = 1'b0;
        h_d   = '0;
        v_d   = '0;
        if (I_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!vld_q) begin
          vld_d  = 1'b1;
          mode_d = I_mode;
        end else if (h_q == H_LAST) begin
          h_d = '0;
          if (v_q == V_LAST) begin
            v_d    = '0;
            fcnt_d = fcnt_q + 8'd1;
            if (I_en) begin
              mode_d = I_mode;
            end else begin
              state_d = ST_IDLE;
              vld_d   = 1'b0;
            end
          end else begin
            v_d = v_q + 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // Region decode, gray value and error-flag bookkeeping for this position.
  always_comb begin
    act    = vld_q && (h32 < HA) && (v32 < VA);
    hs_raw = vld_q && (h32 >= HS_BEG) && (h32 < HS_END);
    vs_raw = vld_q && (v32 >= VS_BEG) && (v32 < VS_END);
    unique case (mode_q)
      2'd0:    g = h32[7:0];
      2'd1:    g = v32[7:0];
      2'd2:    g = fcnt_q;
      default: g = (h32[4] ^ v32[4]) ? 8'hFF : 8'h00;
    endcase
    consume = act && pend_q;
    pend_d  = consume ? 1'b0 : (pend_q | req_q);
    rgb_d   = act ? {g, g, g ^ {7'd0, consume}} : 24'h0;
  end

  // Control state; request is staged once before it can arm the flag.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= ST_IDLE;
      vld_q   <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      fcnt_q  <= '0;
      mode_q  <= '0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      h_q     <= h_d;
      v_q     <= v_d;
      fcnt_q  <= fcnt_d;
      mode_q  <= mode_d;
      req_q   <= I_err_inject;
      pend_q  <= pend_d;
    end
  end

  // Registered pixel and sync outputs, one cycle behind the counters.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_RGB_data     <= 24'h0;
      O_de           <= 1'b0;
      O_hsync        <= ~SYNC_POL;
      O_vsync        <= ~SYNC_POL;
      O_frame_start  <= 1'b0;
      O_err_injected <= 1'b0;
    end else begin
      O_RGB_data     <= rgb_d;
      O_de           <= act;
      O_hsync        <= hs_raw ^ ~SYNC_POL;
      O_vsync        <= vs_raw ^ ~SYNC_POL;
      O_frame_start  <= act && (h_q == '0) && (v_q == '0);
      O_err_injected <= consume;
    end
  end

endmodule

// File: tb/tb_rgb_gray_pattern_gen.sv
// Bench for rgb_gray_pattern_gen on a 14x7 raster.
// Frame-index model compared every cycle, plus literal spot checks.
module tb_rgb_gray_pattern_gen;

  localparam int HT = 14;
  localparam int VT = 7;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_en = 1'b0;
  logic [1:0]  I_mode = 2'd0;
  logic        I_err_inject = 1'b0;
  logic [23:0] O_RGB_data;
  logic        O_de, O_hsync, O_vsync;
  logic        O_frame_start, O_err_injected;

  rgb_gray_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .I_en(I_en),
    .I_mode(I_mode),
    .I_err_inject(I_err_inject),
    .O_RGB_data(O_RGB_data),
    .O_de(O_de),
    .O_hsync(O_hsync),
    .O_vsync(O_vsync),
    .O_frame_start(O_frame_start),
    .O_err_injected(O_err_injected)
  );

  always #5 I_clk = ~I_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int shown = 0;

  bit   m_valid = 0;
  bit   m_idle = 1;
  int   m_n = 0;
  int   m_fc = 0;
  int   m_mode = 0;
  bit   m_pend = 0;
  bit   m_req = 0;
  logic [23:0] e_rgb;
  logic e_de, e_hs, e_vs, e_fs, e_inj;

  // Model: m_n is the index within the frame of the pixel shown after this edge.
  task automatic model_edge();
    int h, v, g;
    bit act, cons;
    logic [7:0] g8;
    e_rgb = 24'h0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_inj = 0;
    if (I_rst) begin
      m_valid = 1; m_idle = 1; m_fc = 0;
      m_pend = 0; m_req = 0; m_mode = 0;
      return;
    end
    cons = 0;
    if (m_idle) begin
      if (I_en) begin m_idle = 0; m_n = -2; end
    end else begin
      m_n++;
      if (m_n == -1) begin
        m_mode = int'(I_mode);
      end else if (m_n >= 0) begin
        h = m_n % HT; v = m_n / HT;
        act = (h < 8) && (v < 4);
        case (m_mode)
          0: g = h % 256;
          1: g = v % 256;
          2: g = m_fc;
          default: g = (((h ^ v) >> 4) & 1) != 0 ? 255 : 0;
        endcase
        g8 = 8'(g);
        cons = act && m_pend;
        e_de = act;
        e_rgb = act ? {g8, g8, g8 ^ {7'd0, cons}} : 24'h0;
        e_hs = (h >= 10) && (h < 12);
        e_vs = (v == 5);
        e_fs = (m_n == 0);
        e_inj = cons;
        if (m_n == HT * VT - 1) begin
          m_fc = (m_fc + 1) % 256;
          if (I_en) begin m_n = -1; m_mode = int'(I_mode); end
          else m_idle = 1;
        end
      end
    end
    m_pend = cons ? 1'b0 : (m_pend | m_req);
    m_req = I_err_inject;
  endtask

  // One clock: advance model on the rising edge, compare on the falling edge.
  task automatic step();
    logic [28:0] got, exp;
    @(posedge I_clk);
    model_edge();
    cyc++;
    @(negedge I_clk);
    if (m_valid) begin
      got = {O_RGB_data, O_de, O_hsync, O_vsync, O_frame_start, O_err_injected};
      exp = {e_rgb, e_de, e_hs, e_vs, e_fs, e_inj};
      checks++;
      if (got !== exp) begin
        errors++;
        if (shown < 20) begin
          shown++;
          $display("FAIL cycle%0d: got rgb=%h de%b hs%b vs%b fs%b inj%b, need rgb=%h de%b hs%b vs%b fs%b inj%b",
                   cyc, O_RGB_data, O_de, O_hsync, O_vsync, O_frame_start, O_err_injected,
                   e_rgb, e_de, e_hs, e_vs, e_fs, e_inj);
        end
      end
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h need %h", name, act, exp);
    end
  endtask

  task automatic wait_fs(input int bound);
    int n = 0;
    do begin
      step();
      n++;
    end while (!O_frame_start && n < bound);
    if (!O_frame_start) begin
      errors++;
      checks++;
      $display("FAIL frame_start_timeout: got none need pulse within %0d", bound);
    end
  endtask

  int k, t0, cnt;
  logic [23:0] prev;

  initial begin
    // reset
    steps(2);
    I_rst = 1'b0;
    lit("reset_rgb", 32'(O_RGB_data), 32'h0);
    lit("reset_de", 32'(O_de), 32'h0);
    lit("reset_hsync", 32'(O_hsync), 32'h0);

    // start from idle, mode 0 ramp
    I_en = 1'b1;
    k = cyc + 1;
    wait_fs(20);
    lit("start_latency", 32'(cyc - k), 32'd2);
    steps(3);
    lit("ramp_h3", 32'(O_RGB_data), 32'h030303);
    steps(7);
    lit("hsync_h10", 32'(O_hsync), 32'h1);
    steps(2);
    lit("hsync_h12", 32'(O_hsync), 32'h0);
    t0 = cyc - 12;
    wait_fs(200);
    lit("frame_period", 32'(cyc - t0), 32'd98);

    // mode change mid-frame
    steps(15);
    I_mode = 2'd1;
    step();
    lit("mode_hold", 32'(O_RGB_data), 32'h020202);
    wait_fs(200);
    I_mode = 2'd0;
    steps(14);
    lit("mode1_line1", 32'(O_RGB_data), 32'h010101);

    // error injection during blanking, second pulse while pending
    wait_fs(200);
    steps(9);
    I_err_inject = 1'b1; step();
    I_err_inject = 1'b0; step();
    I_err_inject = 1'b1; step();
    I_err_inject = 1'b0;
    steps(2);
    lit("inj_flag", 32'(O_err_injected), 32'h1);
    lit("inj_pixel", 32'(O_RGB_data), 32'h000001);
    cnt = 0;
    for (int i = 0; i < 83; i++) begin
      step();
      if (O_err_injected) cnt++;
    end
    lit("inj_once", 32'(cnt), 32'd0);

    // flat field across 257 frames
    I_rst = 1'b1; I_mode = 2'd2;
    step();
    I_rst = 1'b0;
    wait_fs(20);
    lit("flat_first", 32'(O_RGB_data), 32'h000000);
    for (int i = 1; i <= 256; i++) begin
      wait_fs(200);
      if (i == 255) lit("flat_255", 32'(O_RGB_data), 32'hFFFFFF);
      if (i == 256) lit("flat_wrap", 32'(O_RGB_data), 32'h000000);
    end

    // drop enable mid-frame, then restart
    prev = O_RGB_data;
    steps(40);
    I_en = 1'b0;
    steps(60);
    lit("idle_de", 32'(O_de), 32'h0);
    lit("idle_rgb", 32'(O_RGB_data), 32'h0);
    I_en = 1'b1;
    k = cyc + 1;
    wait_fs(20);
    lit("restart_latency", 32'(cyc - k), 32'd2);
    lit("fc_continue", 32'(O_RGB_data), 32'(prev + 24'h010101));

    // reset mid-line with an error pending
    steps(9);
    I_err_inject = 1'b1; step();
    I_err_inject = 1'b0;
    steps(2);
    I_rst = 1'b1;
    step();
    lit("rst_rgb", 32'(O_RGB_data), 32'h0);
    lit("rst_de", 32'(O_de), 32'h0);
    I_rst = 1'b0;
    wait_fs(20);
    lit("rst_fc", 32'(O_RGB_data), 32'h000000);
    cnt = 0;
    for (int i = 0; i < 98; i++) begin
      step();
      if (O_err_injected) cnt++;
    end
    lit("rst_clears_pend", 32'(cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
